alu_seq_ctrl: RTL

- Initiator-side sequencer for the 32-bit ripple ALU (`src1`/`src2`/`less`/`A_invert`/`B_invert`/`cin`/`operation` → `result`/`cout`/`overflow`).
- Accepts 4-bit ALU-control requests over a valid/ready handshake and drives the ALU's control and operand lines from registers.
- Samples the ALU outputs and returns a result with flags over a second valid/ready handshake.
- SLT runs as two ALU passes: subtract, then LESS with `less` fed back. This replaces the combinational set/less wiring.

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu32.sv | 34 +++
 rtl/alu_op_decode.sv | 39 +++
 rtl/alu_seq_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: request opcodes, ALU operation
// encodings and the sequencer state type.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    localparam logic [1:0] ALU_AND  = 2'b00;
    localparam logic [1:0] ALU_OR   = 2'b01;
    localparam logic [1:0] ALU_ADD  = 2'b10;
    localparam logic [1:0] ALU_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SLT2 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu32.sv
// Behavioural model of the 32-bit ripple ALU driven by the sequencer:
// LESS places `less` in bit 0; cout/overflow always come from the adder.
module alu32 (
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        less,
    input  logic        A_invert,
    input  logic        B_invert,
    input  logic        cin,
    input  logic [1:0]  operation,
    output logic [31:0] result,
    output logic        cout,
    output logic        overflow
);

    logic [31:0] a_eff;
    logic [31:0] b_eff;
    logic [32:0] sum;

    always_comb begin
        a_eff    = A_invert ? ~src1 : src1;
        b_eff    = B_invert ? ~src2 : src2;
        sum      = {1'b0, a_eff} + {1'b0, b_eff} + {32'd0, cin};
        cout     = sum[32];
        overflow = (a_eff[31] == b_eff[31]) && (sum[31] != a_eff[31]);
        case (operation)
            2'b00:   result = a_eff & b_eff;
            2'b01:   result = a_eff | b_eff;
            2'b10:   result = sum[31:0];
            default: result = {31'd0, less};
        endcase
    end

endmodule

// File: rtl/alu_op_decode.sv
// Combinational request-opcode decoder producing the ALU control lines
// plus classification flags used by the sequencer.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op,
    output logic           a_inv,
    output logic           b_inv,
    output logic           cin,
    output logic [1:0]     operation,
    output logic           is_slt,
    output logic           is_logic,
    output logic           illegal
);

    always_comb begin
        a_inv     = 1'b0;
        b_inv     = 1'b0;
        cin       = 1'b0;
        operation = ALU_AND;
        is_slt    = 1'b0;
        is_logic  = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_AND:  begin operation = ALU_AND; is_logic = 1'b1; end
            OP_OR:   begin operation = ALU_OR;  is_logic = 1'b1; end
            OP_ADD:  operation = ALU_ADD;
            OP_SUB:  begin b_inv = 1'b1; cin = 1'b1; operation = ALU_ADD; end
            // SLT starts as a subtract; the LESS pass is issued by the sequencer.
            OP_SLT:  begin b_inv = 1'b1; cin = 1'b1; operation = ALU_ADD; is_slt = 1'b1; end
            OP_NOR:  begin a_inv = 1'b1; b_inv = 1'b1; operation = ALU_AND; is_logic = 1'b1; end
            OP_NAND: begin a_inv = 1'b1; b_inv = 1'b1; operation = ALU_OR;  is_logic = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer for the ripple ALU. Drives ALU controls from
// registers, samples its outputs, and runs SLT as subtract followed by LESS.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [OPW-1:0]   req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic [WIDTH-1:0] alu_src1_o,
    output logic [WIDTH-1:0] alu_src2_o,
    output logic             alu_less_o,
    output logic             alu_a_invert_o,
    output logic             alu_b_invert_o,
    output logic             alu_cin_o,
    output logic [1:0]       alu_operation_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_cout_i,
    input  logic             alu_overflow_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_cout_o,
    output logic             rsp_overflow_o,
    output logic             rsp_err_o
);

    state_t     state_q, state_d;
    logic       is_slt_q, is_logic_q;
    logic       req_fire;
    logic       dec_a_inv, dec_b_inv, dec_cin, dec_is_slt, dec_is_logic, dec_illegal;
    logic [1:0] dec_operation;

    alu_op_decode #(.OPW(OPW)) u_decode (
        .op        (req_op_i),
        .a_inv     (dec_a_inv),
        .b_inv     (dec_b_inv),
        .cin       (dec_cin),
        .operation (dec_operation),
        .is_slt    (dec_is_slt),
        .is_logic  (dec_is_logic),
        .illegal   (dec_illegal)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_o = (state_q == ST_IDLE);
        rsp_valid_o = (state_q == ST_RESP);
        req_fire    = req_valid_i && req_ready_o;
        case (state_q)
            ST_IDLE: if (req_fire) state_d = dec_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: state_d = is_slt_q ? ST_SLT2 : ST_RESP;
            ST_SLT2: state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_src1_o      <= '0;
            alu_src2_o      <= '0;
            alu_less_o      <= 1'b0;
            alu_a_invert_o  <= 1'b0;
            alu_b_invert_o  <= 1'b0;
            alu_cin_o       <= 1'b0;
            alu_operation_o <= 2'b00;
            is_slt_q        <= 1'b0;
            is_logic_q      <= 1'b0;
            rsp_result_o    <= '0;
            rsp_zero_o      <= 1'b0;
            rsp_cout_o      <= 1'b0;
            rsp_overflow_o  <= 1'b0;
            rsp_err_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_fire) begin
                    alu_src1_o      <= req_a_i;
                    alu_src2_o      <= req_b_i;
                    alu_less_o      <= 1'b0;
                    alu_a_invert_o  <= dec_a_inv;
                    alu_b_invert_o  <= dec_b_inv;
                    alu_cin_o       <= dec_cin;
                    alu_operation_o <= dec_operation;
                    is_slt_q        <= dec_is_slt;
                    is_logic_q      <= dec_is_logic;
                    if (dec_illegal) begin
                        rsp_result_o   <= '0;
                        rsp_zero_o     <= 1'b1;
                        rsp_cout_o     <= 1'b0;
                        rsp_overflow_o <= 1'b0;
                        rsp_err_o      <= 1'b1;
                    end
                end
                ST_EXEC: if (is_slt_q) begin
                    // Signed less-than: sign of the difference corrected by overflow.
                    alu_operation_o <= ALU_LESS;
                    alu_less_o      <= alu_result_i[WIDTH-1] ^ alu_overflow_i;
                end else begin
                    rsp_result_o   <= alu_result_i;
                    rsp_zero_o     <= (alu_result_i == '0);
                    rsp_cout_o     <= is_logic_q ? 1'b0 : alu_cout_i;
                    rsp_overflow_o <= is_logic_q ? 1'b0 : alu_overflow_i;
                    rsp_err_o      <= 1'b0;
                end
                ST_SLT2: begin
                    rsp_result_o   <= alu_result_i;
                    rsp_zero_o     <= (alu_result_i == '0);
                    rsp_cout_o     <= 1'b0;
                    rsp_overflow_o <= 1'b0;
                    rsp_err_o      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
